// File: rtl/k68_sasc_pump_pkg.sv
// Shared constants for the SASC pump: UART register map, status bits and FSM encodings.
package k68_sasc_pump_pkg;

   localparam logic [15:0] K68_UART_ADR_DATA   = 16'h0000;
   localparam logic [15:0] K68_UART_ADR_STATUS = 16'h0001;

   localparam int STAT_RX_EMPTY = 0;
   localparam int STAT_TX_FULL  = 1;

   typedef enum logic [2:0] {
      K68_PUMP_IDLE = 3'd0,
      K68_PUMP_SREQ = 3'd1,
      K68_PUMP_SCHK = 3'd2,
      K68_PUMP_RREQ = 3'd3,
      K68_PUMP_RCAP = 3'd4,
      K68_PUMP_TWR  = 3'd5
   } pump_state_e;

endpackage

// File: rtl/k68_sasc_pump_fifo.sv
// 8-bit synchronous show-ahead FIFO, 2**AW entries; push-on-full and pop-on-empty are dropped.
module k68_sasc_fifo #(
   parameter int AW = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic [7:0] din_i,
   input  logic       pop_i,
   output logic [7:0] dout_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [7:0]    mem_q [2**AW];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == DEPTH);
   assign empty_o = (cnt_q == '0);
   // Full blocks a push even when a pop lands in the same cycle.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign dout_o  = mem_q[rd_q];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/k68_sasc_pump.sv
// Polls SASC STATUS and shuttles bytes between the host TX/RX FIFOs and the SASC DATA register.
module k68_sasc_pump
   import k68_sasc_pump_pkg::*;
#(
   parameter int          AW       = 2,
   parameter logic [15:0] ADR_STAT = K68_UART_ADR_STATUS,
   parameter logic [15:0] ADR_DATA = K68_UART_ADR_DATA
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  tx_dat_i,
   input  logic        tx_we_i,
   output logic        tx_full_o,
   output logic [7:0]  rx_dat_o,
   input  logic        rx_re_i,
   output logic        rx_empty_o,
   output logic        irq_o,
   output logic [15:0] u_add_o,
   output logic [7:0]  u_dat_o,
   output logic        u_cs_o,
   output logic        u_we_o,
   input  logic [7:0]  u_dat_i
);

   pump_state_e state_q;
   logic        cs_q, we_q;
   logic [15:0] add_q;
   logic [7:0]  dat_q;

   logic [7:0]  tx_head;
   logic        tx_empty, rx_full;
   logic        go_rx, go_tx;

   // RX wins over TX; RX is only serviced when the local FIFO has room, so RCAP cannot overflow.
   assign go_rx = (state_q == K68_PUMP_SCHK) & ~u_dat_i[STAT_RX_EMPTY] & ~rx_full;
   assign go_tx = (state_q == K68_PUMP_SCHK) & ~go_rx & ~u_dat_i[STAT_TX_FULL] & ~tx_empty;

   k68_sasc_fifo #(.AW(AW)) u_tx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (tx_we_i),
      .din_i   (tx_dat_i),
      .pop_i   (go_tx),
      .dout_o  (tx_head),
      .full_o  (tx_full_o),
      .empty_o (tx_empty)
   );

   k68_sasc_fifo #(.AW(AW)) u_rx_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (state_q == K68_PUMP_RCAP),
      .din_i   (u_dat_i),
      .pop_i   (rx_re_i),
      .dout_o  (rx_dat_o),
      .full_o  (rx_full),
      .empty_o (rx_empty_o)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= K68_PUMP_IDLE;
         cs_q    <= 1'b0;
         we_q    <= 1'b0;
         add_q   <= '0;
         dat_q   <= '0;
      end else begin
         cs_q <= 1'b0;
         we_q <= 1'b0;
         case (state_q)
            K68_PUMP_IDLE: begin
               state_q <= K68_PUMP_SREQ;
               cs_q    <= 1'b1;
               add_q   <= ADR_STAT;
            end
            K68_PUMP_SREQ: state_q <= K68_PUMP_SCHK;
            K68_PUMP_SCHK: begin
               if (go_rx) begin
                  state_q <= K68_PUMP_RREQ;
                  cs_q    <= 1'b1;
                  add_q   <= ADR_DATA;
               end else if (go_tx) begin
                  state_q <= K68_PUMP_TWR;
                  cs_q    <= 1'b1;
                  we_q    <= 1'b1;
                  add_q   <= ADR_DATA;
                  dat_q   <= tx_head;
               end else begin
                  state_q <= K68_PUMP_IDLE;
               end
            end
            K68_PUMP_RREQ: state_q <= K68_PUMP_RCAP;
            K68_PUMP_RCAP: state_q <= K68_PUMP_IDLE;
            K68_PUMP_TWR:  state_q <= K68_PUMP_IDLE;
            default:       state_q <= K68_PUMP_IDLE;
         endcase
      end
   end

   assign u_cs_o  = cs_q;
   assign u_we_o  = we_q;
   assign u_add_o = add_q;
   assign u_dat_o = dat_q;
   assign irq_o   = ~rx_empty_o;

endmodule

// File: tb/tb_k68_sasc_pump.sv
// Bench for k68_sasc_pump: behavioural SASC slave plus queue-based host FIFO reference model.
module tb_k68_sasc_pump;
   import k68_sasc_pump_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  tx_dat_i;
   logic        tx_we_i, tx_full_o;
   logic [7:0]  rx_dat_o;
   logic        rx_re_i, rx_empty_o, irq_o;
   logic [15:0] u_add_o;
   logic [7:0]  u_dat_o;
   logic        u_cs_o, u_we_o;
   logic [7:0]  u_dat_i;

   always #5 clk = ~clk;

   k68_sasc_pump dut (
      .clk_i(clk), .rst_i(rst),
      .tx_dat_i(tx_dat_i), .tx_we_i(tx_we_i), .tx_full_o(tx_full_o),
      .rx_dat_o(rx_dat_o), .rx_re_i(rx_re_i), .rx_empty_o(rx_empty_o), .irq_o(irq_o),
      .u_add_o(u_add_o), .u_dat_o(u_dat_o), .u_cs_o(u_cs_o), .u_we_o(u_we_o),
      .u_dat_i(u_dat_i)
   );

   typedef struct { int unsigned rdy; logic [7:0] b; } cap_t;

   logic [7:0]  sasc_rxq[$];
   logic [7:0]  sasc_txlog[$];
   cap_t        capq[$];
   bit          loop_en = 0, stat_txfull = 0, force_en = 0;
   logic [7:0]  force_val = 8'h00;
   int unsigned edge_n = 0;
   int          n_stat_rd = 0, n_dat_rd = 0, n_dat_wr = 0;

   logic [7:0]  htx[$], hrx[$];
   int          checks = 0, errors = 0;
   bit          prev_cs = 0;

   // SASC slave: registered read data, DATA read pops its RX queue, DATA write logs (and loops back).
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         u_dat_i <= 8'h00;
         capq.delete();
      end else begin
         edge_n++;
         if (u_cs_o) begin
            if (u_we_o) begin
               if (u_add_o == K68_UART_ADR_DATA) begin
                  sasc_txlog.push_back(u_dat_o);
                  n_dat_wr++;
                  if (loop_en) sasc_rxq.push_back(u_dat_o);
               end
            end else if (u_add_o == K68_UART_ADR_STATUS) begin
               n_stat_rd++;
               u_dat_i <= force_en ? force_val
                                   : {6'b0, stat_txfull, (sasc_rxq.size() == 0)};
            end else if (u_add_o == K68_UART_ADR_DATA) begin
               n_dat_rd++;
               if (sasc_rxq.size() > 0) begin
                  capq.push_back('{edge_n + 1, sasc_rxq[0]});
                  u_dat_i <= sasc_rxq.pop_front();
               end else begin
                  u_dat_i <= 8'hEE;
               end
            end
         end
      end
   end

   // One clock: drive after a negedge, then check every observable at the following negedge.
   task automatic step(input logic we, input logic [7:0] b, input logic re);
      tx_we_i  = we;
      tx_dat_i = b;
      rx_re_i  = re;
      if (we && htx.size() < 4) htx.push_back(b);
      if (re && hrx.size() > 0) void'(hrx.pop_front());
      @(posedge clk);
      @(negedge clk);
      tx_we_i = 1'b0;
      rx_re_i = 1'b0;
      while (capq.size() > 0 && capq[0].rdy <= edge_n) begin
         hrx.push_back(capq[0].b);
         void'(capq.pop_front());
      end
      if (u_cs_o && u_we_o) begin
         checks++;
         if (htx.size() == 0 || u_add_o !== K68_UART_ADR_DATA || u_dat_o !== htx[0]) begin
            errors++;
            $display("FAIL bus_write: got add=%h dat=%h, model queue size %0d head %h",
                     u_add_o, u_dat_o, htx.size(), (htx.size() > 0) ? htx[0] : 8'hxx);
         end
         if (htx.size() > 0) void'(htx.pop_front());
      end
      checks++;
      if (u_cs_o && prev_cs) begin
         errors++;
         $display("FAIL cs_back_to_back: cs high on consecutive cycles");
      end
      prev_cs = u_cs_o;
      checks++;
      if (tx_full_o !== (htx.size() == 4)) begin
         errors++;
         $display("FAIL tx_full: got %b want %b", tx_full_o, (htx.size() == 4));
      end
      checks++;
      if (rx_empty_o !== (hrx.size() == 0) || irq_o !== (hrx.size() != 0)) begin
         errors++;
         $display("FAIL rx_empty_irq: got empty=%b irq=%b, model size %0d", rx_empty_o, irq_o, hrx.size());
      end
      if (hrx.size() > 0) begin
         checks++;
         if (rx_dat_o !== hrx[0]) begin
            errors++;
            $display("FAIL rx_dat: got %h want %h", rx_dat_o, hrx[0]);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_reset;
      int to;
      rst = 1'b1; tx_we_i = 1'b0; rx_re_i = 1'b0; tx_dat_i = 8'h00;
      repeat (3) @(negedge clk);
      checks++;
      if (u_cs_o !== 1'b0 || u_we_o !== 1'b0 || u_add_o !== 16'h0 || u_dat_o !== 8'h0 ||
          tx_full_o !== 1'b0 || rx_empty_o !== 1'b1 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: cs=%b we=%b add=%h dat=%h full=%b empty=%b irq=%b",
                  u_cs_o, u_we_o, u_add_o, u_dat_o, tx_full_o, rx_empty_o, irq_o);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
      to = 0;
      while (!(u_cs_o && u_we_o) && to < 30) begin idle(1); to++; end
      checks++;
      if (to >= 30) begin errors++; $display("FAIL reset_twr_timeout: no write seen"); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (u_cs_o !== 1'b0 || tx_full_o !== 1'b0 || rx_empty_o !== 1'b1 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_twr: cs=%b full=%b empty=%b irq=%b", u_cs_o, tx_full_o, rx_empty_o, irq_o);
      end
      htx.delete(); hrx.delete(); prev_cs = 0;
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      checks++;
      if (u_cs_o !== 1'b1 || u_we_o !== 1'b0 || u_add_o !== K68_UART_ADR_STATUS) begin
         errors++;
         $display("FAIL reset_resume: cs=%b we=%b add=%h want status read", u_cs_o, u_we_o, u_add_o);
      end
      to = n_dat_wr;
      idle(12);
      checks++;
      if (n_dat_wr !== to) begin
         errors++;
         $display("FAIL reset_flush: %0d writes after reset, want 0", n_dat_wr - to);
      end
   endtask

   task automatic test_tx_latency;
      int to, wr0;
      to = 0;
      while (!(u_cs_o && !u_we_o && u_add_o == K68_UART_ADR_STATUS) && to < 10) begin idle(1); to++; end
      idle(2);
      checks++;
      if (to >= 10 || u_cs_o !== 1'b0) begin
         errors++;
         $display("FAIL tx_sync: could not align to poll cycle (to=%0d cs=%b)", to, u_cs_o);
      end
      wr0 = n_dat_wr;
      step(1'b1, 8'hA5, 1'b0);
      checks++;
      if (!(u_cs_o && !u_we_o && u_add_o == K68_UART_ADR_STATUS)) begin
         errors++;
         $display("FAIL tx_lat_c2: cs=%b we=%b add=%h want status read", u_cs_o, u_we_o, u_add_o);
      end
      idle(1);
      idle(1);
      checks++;
      if (!(u_cs_o && u_we_o && u_dat_o == 8'hA5)) begin
         errors++;
         $display("FAIL tx_lat_c4: cs=%b we=%b dat=%h want write of a5", u_cs_o, u_we_o, u_dat_o);
      end
      idle(10);
      checks++;
      if (n_dat_wr - wr0 != 1) begin
         errors++;
         $display("FAIL tx_single_pulse: %0d writes want 1", n_dat_wr - wr0);
      end
   endtask

   task automatic test_loopback;
      int to;
      loop_en = 1;
      step(1'b1, 8'h3C, 1'b0);
      to = 0;
      while (rx_empty_o && to < 40) begin idle(1); to++; end
      checks++;
      if (rx_empty_o !== 1'b0 || irq_o !== 1'b1 || rx_dat_o !== 8'h3C) begin
         errors++;
         $display("FAIL loopback_rx: empty=%b irq=%b dat=%h want 0/1/3c", rx_empty_o, irq_o, rx_dat_o);
      end
      step(1'b0, 8'h00, 1'b1);
      checks++;
      if (rx_empty_o !== 1'b1 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL loopback_pop: empty=%b irq=%b want 1/0", rx_empty_o, irq_o);
      end
      loop_en = 0;
   endtask

   task automatic test_tx_overflow;
      int l0;
      stat_txfull = 1;
      idle(4);
      l0 = sasc_txlog.size();
      for (int i = 1; i <= 5; i++) begin
         step(1'b1, 8'(i), 1'b0);
         if (i == 4) begin
            checks++;
            if (tx_full_o !== 1'b1) begin errors++; $display("FAIL tx_full_after4: got %b want 1", tx_full_o); end
         end
      end
      stat_txfull = 0;
      idle(40);
      checks++;
      if (sasc_txlog.size() - l0 != 4) begin
         errors++;
         $display("FAIL tx_overflow_count: %0d bytes sent want 4", sasc_txlog.size() - l0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (sasc_txlog[l0 + i] !== 8'(i + 1)) begin
               errors++;
               $display("FAIL tx_overflow_order: byte %0d got %h want %h", i, sasc_txlog[l0 + i], 8'(i + 1));
            end
         end
      end
   endtask

   task automatic test_status_block;
      int wr0, rd0, st0;
      // 8'h03: SASC TX full and SASC RX empty, so the pump may only poll.
      force_en = 1; force_val = 8'h03;
      idle(4);
      step(1'b1, 8'h77, 1'b0);
      step(1'b1, 8'h88, 1'b0);
      wr0 = n_dat_wr; rd0 = n_dat_rd; st0 = n_stat_rd;
      idle(30);
      checks++;
      if (n_dat_wr != wr0 || n_dat_rd != rd0 || n_stat_rd - st0 < 5) begin
         errors++;
         $display("FAIL status_block: wr=%0d rd=%0d stat=%0d want 0/0/>=5",
                  n_dat_wr - wr0, n_dat_rd - rd0, n_stat_rd - st0);
      end
      force_en = 0;
      idle(30);
      checks++;
      if (htx.size() != 0) begin errors++; $display("FAIL status_release: %0d bytes stuck", htx.size()); end
   endtask

   task automatic test_rx_full;
      int to, rd0;
      logic [7:0] got[$];
      for (int i = 0; i < 5; i++) sasc_rxq.push_back(8'h60 + 8'(i));
      to = 0;
      while (hrx.size() < 4 && to < 80) begin idle(1); to++; end
      idle(10);
      rd0 = n_dat_rd;
      idle(20);
      checks++;
      if (n_dat_rd != rd0 || sasc_rxq.size() != 1) begin
         errors++;
         $display("FAIL rx_full_hold: reads=%0d pending=%0d want 0/1", n_dat_rd - rd0, sasc_rxq.size());
      end
      got.push_back(rx_dat_o);
      step(1'b0, 8'h00, 1'b1);
      to = 0;
      while (n_dat_rd == rd0 && to < 20) begin idle(1); to++; end
      checks++;
      if (n_dat_rd == rd0) begin errors++; $display("FAIL rx_full_resume: no DATA read after pop"); end
      idle(4);
      for (int i = 0; i < 4; i++) begin
         got.push_back(rx_dat_o);
         step(1'b0, 8'h00, 1'b1);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got[i] !== 8'h60 + 8'(i)) begin
            errors++;
            $display("FAIL rx_full_order: byte %0d got %h want %h", i, got[i], 8'h60 + 8'(i));
         end
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 63) == 0) loop_en = ~loop_en;
         if ($urandom_range(0, 15) == 0) stat_txfull = ~stat_txfull;
         if (!loop_en && $urandom_range(0, 9) == 0) sasc_rxq.push_back(8'($urandom));
         step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 1) == 1);
      end
      loop_en = 0; stat_txfull = 0;
      for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b1);
      checks++;
      if (htx.size() != 0 || hrx.size() != 0 || sasc_rxq.size() != 0) begin
         errors++;
         $display("FAIL random_drain: tx=%0d rx=%0d sasc=%0d left", htx.size(), hrx.size(), sasc_rxq.size());
      end
   endtask

   initial begin
      test_reset();
      test_tx_latency();
      test_loopback();
      test_tx_overflow();
      test_status_block();
      test_rx_full();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
